alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- ID/EX operand stage sitting directly upstream of the ALU compare/arith units, including the signed set-less-than unit.
- Registers decoded operands, ALU op and destination register. Presents them to the ALU with a per-unit enable, one-hot decoded.
- Uses a 2-entry buffer (head + skid) with valid/ready handshakes on both sides, plus a synchronous flush for branch mispredict.

Parameters:
WIDTH, 32, operand width in bits
OPW, 3, ALU op code width; encodings come from alu_pkg
RDW, 5, destination register index width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous squash of all buffered entries
in_valid  input  1  decode stage presents an instruction
in_ready  output  1  stage can accept; registered
in_data0  input  WIDTH  operand A (rs)
in_data1  input  WIDTH  operand B (rt/imm)
in_op  input  OPW  ALU op code
in_rd  input  RDW  destination register
out_valid  output  1  head entry valid
out_ready  input  1  ALU/EX consumer accepts head
out_data0  output  WIDTH  head operand A
out_data1  output  WIDTH  head operand B
out_op  output  OPW  head op code
out_rd  output  RDW  head destination
out_slt_en  output  1  enable for SLT unit
out_add_en  output  1  enable for add/sub unit
out_logic_en  output  1  enable for and/or/xor unit
occupancy  output  2  entries held (0..2)

Behaviour:
- Clock, reset and handshake definitions:
  - One clock: clk. Reset: rst_n, asynchronous assert, active-low.
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready.
- Reset state:
  - State EMPTY, in_ready=1, out_valid=0, occupancy=0.
  - All payload outputs 0 and all unit enables 0.
- FSM states and transitions:
  - EMPTY: push -> ONE (head <= input).
  - ONE:
    - push&pop -> ONE (head <= input).
    - push only -> TWO (skid <= input).
    - pop only -> EMPTY.
    - neither -> ONE.
  - TWO: in_ready=0, so no push. pop -> ONE (head <= skid). No pop -> TWO.
- Timing:
  - Latency: an instruction accepted at edge N is visible on out_* after edge N. Zero bubbles when the consumer is always ready.
  - in_ready is registered: next in_ready = (next state != TWO). It never combinationally depends on out_ready.
- Output stability:
  - While out_valid=1 and out_ready=0, all out_* stay stable.
  - Order is strictly FIFO.
- Payload outputs:
  - When out_valid=0, out_data0/1, out_op and out_rd are driven 0.
- Unit enables (combinational from head, gated by out_valid):
  - out_slt_en = out_valid & (out_op==OP_SLT).
  - out_add_en = out_valid & (op==OP_ADD | op==OP_SUB).
  - out_logic_en = out_valid & (op in AND/OR/XOR).
  - Unknown op codes give all enables 0 and still flow through.
  - At most one enable is high at any time.
- Flush:
  - Next state EMPTY and next in_ready=1, regardless of current state.
  - A same-cycle in_valid is discarded; flush wins over push.
  - A same-cycle pop is a completed transfer; the consumer keeps it.
- Reset mid-operation: immediate return to reset values. Buffered entries are lost.
- No arithmetic on operands; values pass bit-exact.
- Assertions:
  - No push when TWO.
  - occupancy == {TWO, ONE} encoding of state.

Decomposition:
- alu_pkg holds:
  - Op enum alu_op_t: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_SLT=5.
  - WIDTH_DEF=32.
  - Struct alu_req_t {data0, data1, op, rd}.
- The FSM state enum stays local to the module.
- One natural sub-module: alu_unit_decode, the combinational op -> one-hot enable decode.
  - It is reused by EX forwarding checks.

Test Plan:
1. Reset:
   - Stimulus: hold rst_n=0 with in_valid=1.
   - Response: in_ready=1, out_valid=0, outputs 0, occupancy=0.
   - Release, push data0=0xFFFFFFFF, data1=0x00000001, op=OP_SLT, rd=3.
   - Response: next cycle out_valid=1, out_slt_en=1, out_add_en=0.
2. Streaming:
   - Stimulus: out_ready=1, push 8 back-to-back ops (ADD,SUB,AND,OR,XOR,SLT,ADD,SLT) with data0=i.
   - Response: outputs appear in order, one per cycle, no bubbles, occupancy never exceeds 1.
3. Backpressure:
   - Stimulus: out_ready=0, push A then B.
   - Response: occupancy=2 and in_ready=0 after the 2nd edge. In_valid on C is ignored. out_* holds A stable.
   - Then out_ready=1: A, then B, then C (after in_ready rises) delivered in order.
4. Flush in TWO:
   - Stimulus: flush together with in_valid=1 and out_ready=1.
   - Response: the head is popped this cycle. Skid and input are discarded. Next cycle out_valid=0, in_ready=1, occupancy=0.
5. Async reset mid-stream:
   - Stimulus: assert rst_n low between edges while occupancy=2.
   - Response: out_valid=0 and in_ready=1 immediately, without waiting for clk.
6. Enable decode:
   - Stimulus: push op=7 (undefined).
   - Response: out_valid=1, all enables 0, out_op=7 passed through.

Source files
------------

// File: rtl/alu_pkg.sv
// Purpose: shared ALU op encodings and request layout for the ID/EX operand stage and EX-side users.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int OPW_DEF   = 3;
  localparam int RDW_DEF   = 5;

  typedef enum logic [OPW_DEF-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLT = 3'd5
  } alu_op_t;

  // Request as presented to the ALU in the default configuration.
  typedef struct packed {
    logic [WIDTH_DEF-1:0] data0;
    logic [WIDTH_DEF-1:0] data1;
    logic [OPW_DEF-1:0]   op;
    logic [RDW_DEF-1:0]   rd;
  } alu_req_t;

endpackage

// File: rtl/alu_unit_decode.sv
// Purpose: combinational op code -> one-hot ALU unit enable decode.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; enables are gated by valid only.
// Ports: valid (entry present), op (ALU op code), slt_en / add_en / logic_en (unit enables).
module alu_unit_decode
  import alu_pkg::*;
#(
  parameter int OPW = 3
) (
  input  logic           valid,
  input  logic [OPW-1:0] op,
  output logic           slt_en,
  output logic           add_en,
  output logic           logic_en
);

  // Undefined codes match none of the compares, so every enable stays low.
  assign slt_en   = valid & (op == OPW'(OP_SLT));
  assign add_en   = valid & ((op == OPW'(OP_ADD)) | (op == OPW'(OP_SUB)));
  assign logic_en = valid & ((op == OPW'(OP_AND)) | (op == OPW'(OP_OR)) |
                             (op == OPW'(OP_XOR)));

endmodule

// File: rtl/alu_operand_stage.sv
// Purpose: ID/EX operand register stage (head + skid) feeding the ALU with one-hot unit enables.
// Latency: 1 cycle; an instruction accepted at edge N is on out_* after edge N, no bubbles.
// Backpressure: in_ready is registered and drops only when both entries are full; flush empties.
// Ports: in_* valid/ready decode side, out_* valid/ready ALU side, flush squash, occupancy 0..2.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = 3,
  parameter int RDW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [OPW-1:0]   in_op,
  input  logic [RDW-1:0]   in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [OPW-1:0]   out_op,
  output logic [RDW-1:0]   out_rd,
  output logic             out_slt_en,
  output logic             out_add_en,
  output logic             out_logic_en,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [OPW-1:0]   op;
    logic [RDW-1:0]   rd;
  } req_t;

  state_t state, state_nxt;
  req_t   head, head_nxt, skid, skid_nxt, in_req;
  logic   in_ready_q;
  logic   push, pop;

  assign in_req = '{data0: in_data0, data1: in_data1, op: in_op, rd: in_rd};
  assign push   = in_valid & in_ready_q & ~flush;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    skid_nxt  = skid;
    case (state)
      S_EMPTY: begin
        if (push) begin
          state_nxt = S_ONE;
          head_nxt  = in_req;
        end
      end
      S_ONE: begin
        if (push && pop) begin
          head_nxt = in_req;
        end else if (push) begin
          state_nxt = S_TWO;
          skid_nxt  = in_req;
        end else if (pop) begin
          state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        if (pop) begin
          state_nxt = S_ONE;
          head_nxt  = skid;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
    // A pop in the flush cycle has already completed; only the remaining entries are dropped.
    if (flush) state_nxt = S_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_EMPTY;
      head       <= '0;
      skid       <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      head       <= head_nxt;
      skid       <= skid_nxt;
      // Registered from next state so in_ready never has a path from out_ready.
      in_ready_q <= (state_nxt != S_TWO);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state != S_EMPTY);
  assign occupancy = {state == S_TWO, state == S_ONE};

  // Stale head contents are hidden while empty.
  assign out_data0 = out_valid ? head.data0 : '0;
  assign out_data1 = out_valid ? head.data1 : '0;
  assign out_op    = out_valid ? head.op    : '0;
  assign out_rd    = out_valid ? head.rd    : '0;

  alu_unit_decode #(.OPW(OPW)) u_decode (
    .valid    (out_valid),
    .op       (head.op),
    .slt_en   (out_slt_en),
    .add_en   (out_add_en),
    .logic_en (out_logic_en)
  );

  a_no_push_in_two: assert property (@(posedge clk) disable iff (!rst_n)
    !(state == S_TWO && push));
  a_occ_encoding: assert property (@(posedge clk) disable iff (!rst_n)
    occupancy == {state == S_TWO, state == S_ONE});
  a_ready_tracks_state: assert property (@(posedge clk) disable iff (!rst_n)
    in_ready_q == (state != S_TWO));
  a_enables_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({out_slt_en, out_add_en, out_logic_en}));

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data0 = '0;
  logic [31:0] in_data1 = '0;
  logic [2:0]  in_op = '0;
  logic [4:0]  in_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data0;
  logic [31:0] out_data1;
  logic [2:0]  out_op;
  logic [4:0]  out_rd;
  logic        out_slt_en;
  logic        out_add_en;
  logic        out_logic_en;
  logic [1:0]  occupancy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.WIDTH(32), .OPW(3), .RDW(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data0     (in_data0),
    .in_data1     (in_data1),
    .in_op        (in_op),
    .in_rd        (in_rd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data0    (out_data0),
    .out_data1    (out_data1),
    .out_op       (out_op),
    .out_rd       (out_rd),
    .out_slt_en   (out_slt_en),
    .out_add_en   (out_add_en),
    .out_logic_en (out_logic_en),
    .occupancy    (occupancy)
  );

  task automatic drive(input logic v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [2:0] op, input logic [4:0] rd);
    in_valid = v;
    in_data0 = d0;
    in_data1 = d1;
    in_op    = op;
    in_rd    = rd;
  endtask

  // Advance one active edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'd5, 5'd3);
    step();
    step();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (occupancy !== 2'd0) begin fails++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    tests++; if ({out_data0, out_data1, out_op, out_rd} !== 72'd0) begin fails++;
      $display("FAIL reset_payload: got %h %h %h %h want zeros", out_data0, out_data1, out_op, out_rd); end
    tests++; if ({out_slt_en, out_add_en, out_logic_en} !== 3'b000) begin fails++;
      $display("FAIL reset_enables: got %b%b%b want 000", out_slt_en, out_add_en, out_logic_en); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    drive(1'b0, '0, '0, '0, '0);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL first_out_valid: got %b want 1", out_valid); end
    tests++; if (out_slt_en !== 1'b1 || out_add_en !== 1'b0 || out_logic_en !== 1'b0) begin fails++;
      $display("FAIL first_enables: got slt=%b add=%b logic=%b want 1 0 0", out_slt_en, out_add_en, out_logic_en); end
    tests++; if (out_data0 !== 32'hFFFF_FFFF || out_data1 !== 32'h1 || out_rd !== 5'd3) begin fails++;
      $display("FAIL first_payload: got %h %h rd=%0d want ffffffff 00000001 rd=3", out_data0, out_data1, out_rd); end
    out_ready = 1'b1;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL first_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_streaming();
    logic [2:0] ops [8];
    logic [2:0] en  [8];   // expected {slt, add, logic}
    ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd5};
    en  = '{3'b010, 3'b010, 3'b001, 3'b001, 3'b001, 3'b100, 3'b010, 3'b100};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i), 32'h100 + 32'(i), ops[i], 5'(i + 8));
      step();
      tests++; if (out_valid !== 1'b1 || out_data0 !== 32'(i) || out_data1 !== 32'h100 + 32'(i)
                   || out_op !== ops[i] || out_rd !== 5'(i + 8)) begin fails++;
        $display("FAIL stream_item%0d: got v=%b d0=%h d1=%h op=%0d rd=%0d want v=1 d0=%h d1=%h op=%0d rd=%0d",
                 i, out_valid, out_data0, out_data1, out_op, out_rd, 32'(i), 32'h100 + 32'(i), ops[i], i + 8); end
      tests++; if ({out_slt_en, out_add_en, out_logic_en} !== en[i]) begin fails++;
        $display("FAIL stream_en%0d: got %b%b%b want %b", i, out_slt_en, out_add_en, out_logic_en, en[i]); end
      tests++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin fails++;
        $display("FAIL stream_occ%0d: got occ=%0d rdy=%b want occ=1 rdy=1", i, occupancy, in_ready); end
    end
    drive(1'b0, '0, '0, '0, '0);
    step();
    tests++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin fails++;
      $display("FAIL stream_drain: got v=%b occ=%0d want 0 0", out_valid, occupancy); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 32'hAA, 3'd0, 5'd10);
    step();
    tests++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin fails++;
      $display("FAIL bp_after_a: got occ=%0d rdy=%b want 1 1", occupancy, in_ready); end
    drive(1'b1, 32'hB, 32'hBB, 3'd2, 5'd11);
    step();
    tests++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin fails++;
      $display("FAIL bp_after_b: got occ=%0d rdy=%b want 2 0", occupancy, in_ready); end
    drive(1'b1, 32'hC, 32'hCC, 3'd5, 5'd12);
    step();
    tests++; if (occupancy !== 2'd2 || out_data0 !== 32'hA || out_data1 !== 32'hAA
                 || out_op !== 3'd0 || out_rd !== 5'd10 || out_add_en !== 1'b1) begin fails++;
      $display("FAIL bp_hold_a: got occ=%0d d0=%h d1=%h op=%0d rd=%0d want 2 a aa 0 10",
               occupancy, out_data0, out_data1, out_op, out_rd); end
    out_ready = 1'b1;
    step();
    tests++; if (out_data0 !== 32'hB || out_op !== 3'd2 || occupancy !== 2'd1 || in_ready !== 1'b1) begin fails++;
      $display("FAIL bp_deliver_b: got d0=%h op=%0d occ=%0d rdy=%b want b 2 1 1", out_data0, out_op, occupancy, in_ready); end
    step();
    drive(1'b0, '0, '0, '0, '0);
    tests++; if (out_data0 !== 32'hC || out_rd !== 5'd12 || out_slt_en !== 1'b1 || out_valid !== 1'b1) begin fails++;
      $display("FAIL bp_deliver_c: got d0=%h rd=%0d slt=%b v=%b want c 12 1 1", out_data0, out_rd, out_slt_en, out_valid); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_flush_two();
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 32'h0, 3'd1, 5'd1);
    step();
    drive(1'b1, 32'h22, 32'h0, 3'd3, 5'd2);
    step();
    tests++; if (occupancy !== 2'd2) begin fails++; $display("FAIL flush_setup: got occ=%0d want 2", occupancy); end
    drive(1'b1, 32'h33, 32'h0, 3'd4, 5'd3);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b1 || out_data0 !== 32'h11) begin fails++;
      $display("FAIL flush_head_popped: got v=%b d0=%h want 1 11", out_valid, out_data0); end
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin fails++;
      $display("FAIL flush_empty: got v=%b rdy=%b occ=%0d want 0 1 0", out_valid, in_ready, occupancy); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_input_dropped: got v=%b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h44, 32'h0, 3'd0, 5'd4);
    step();
    drive(1'b1, 32'h55, 32'h0, 3'd0, 5'd5);
    step();
    drive(1'b0, '0, '0, '0, '0);
    tests++; if (occupancy !== 2'd2) begin fails++; $display("FAIL arst_setup: got occ=%0d want 2", occupancy); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin fails++;
      $display("FAIL arst_immediate: got v=%b rdy=%b occ=%0d want 0 1 0", out_valid, in_ready, occupancy); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL arst_entries_lost: got v=%b want 0", out_valid); end
  endtask

  task automatic test_undef_op();
    out_ready = 1'b1;
    drive(1'b1, 32'h1234, 32'h5678, 3'd7, 5'd31);
    step();
    drive(1'b0, '0, '0, '0, '0);
    tests++; if (out_valid !== 1'b1 || out_op !== 3'd7 || out_data0 !== 32'h1234 || out_rd !== 5'd31) begin fails++;
      $display("FAIL undef_pass: got v=%b op=%0d d0=%h rd=%0d want 1 7 1234 31", out_valid, out_op, out_data0, out_rd); end
    tests++; if ({out_slt_en, out_add_en, out_logic_en} !== 3'b000) begin fails++;
      $display("FAIL undef_enables: got %b%b%b want 000", out_slt_en, out_add_en, out_logic_en); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL undef_drain: got v=%b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_two();
    test_async_reset();
    test_undef_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
